if_fetch_stage: RTL and testbench

Instruction-fetch stage between the PC register and the decode stage of the 5-stage MIPS pipeline. Takes the current `pc`, fetches from instruction memory over a req/ready handshake that tolerates wait states, and owns the IF/ID pipeline register: `IF_ID_Instruction`, `IF_ID_PCplus4` and `IF_ID_valid`. Applies hazard-unit stall (`PCcont`) and control-hazard `flush`, absorbing a response that lands during a stall in a one-entry skid buffer. Emits `pc_advance` so the PC register moves only when a fetch is consumed.

---
 rtl/mips_pkg.sv | 12 +
 rtl/if_skid_reg.sv | 34 +++
 rtl/if_fetch_stage.sv | 122 ++++++++++++
 tb/tb_if_fetch_stage.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared constants and FSM encoding for the MIPS pipeline front end.
package mips_pkg;

    localparam logic [31:0] RESET_PC = 32'h0040_0000;
    localparam logic [31:0] NOP      = 32'h0000_0000;

    typedef enum logic [0:0] {
        FETCH   = 1'b0,
        DISCARD = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/if_skid_reg.sv
// One-entry skid buffer holding {instruction, pc+4} for a response that lands while decode is stalled.
module if_skid_reg
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        clear,
    input  logic        drain,
    input  logic [63:0] load_data,
    output logic [63:0] data,
    output logic        valid
);

    logic [63:0] data_reg;
    logic        valid_reg;

    // clear and drain both empty the entry; a load never coincides with either
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_reg  <= {NOP, RESET_PC + 32'd4};
            valid_reg <= 1'b0;
        end else if (clear || drain) begin
            valid_reg <= 1'b0;
        end else if (load) begin
            data_reg  <= load_data;
            valid_reg <= 1'b1;
        end
    end

    assign data  = data_reg;
    assign valid = valid_reg;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch: imem req/ready handshake, IF/ID register, stall skid and flush discard.
module if_fetch_stage
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        PCcont,
    input  logic        flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_ID_Instruction,
    output logic [31:0] IF_ID_PCplus4,
    output logic        IF_ID_valid,
    output logic        pc_advance
);

    fetch_state_t state_reg, state_next;
    logic [31:0]  req_addr_reg;
    logic [31:0]  instr_reg, instr_next;
    logic [31:0]  pcplus4_reg, pcplus4_next;
    logic         valid_reg, valid_next;
    logic [31:0]  pc_plus4;
    logic         skid_load, skid_clear, skid_drain, skid_valid;
    logic [63:0]  skid_data;

    assign pc_plus4 = pc + 32'd4;

    if_skid_reg u_skid (
        .clk       (clk),
        .reset     (reset),
        .load      (skid_load),
        .clear     (skid_clear),
        .drain     (skid_drain),
        .load_data ({imem_rdata, pc_plus4}),
        .data      (skid_data),
        .valid     (skid_valid)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_reg <= FETCH;
        else        state_reg <= state_next;
    end

    // A flush while a request is still waiting must let that response drain unseen
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            FETCH:   if (flush && imem_req && !imem_ready) state_next = DISCARD;
            DISCARD: if (!flush && imem_ready)            state_next = FETCH;
            default: state_next = FETCH;
        endcase
    end

    always_comb begin
        imem_req     = 1'b0;
        imem_addr    = pc;
        pc_advance   = 1'b0;
        instr_next   = instr_reg;
        pcplus4_next = pcplus4_reg;
        valid_next   = valid_reg;
        skid_load    = 1'b0;
        skid_clear   = 1'b0;
        skid_drain   = 1'b0;
        if (reset) begin
            case (state_reg)
                FETCH: begin
                    imem_req = !skid_valid;
                    if (flush) begin
                        instr_next = NOP;
                        valid_next = 1'b0;
                        skid_clear = 1'b1;
                    end else if (skid_valid && !PCcont) begin
                        {instr_next, pcplus4_next} = skid_data;
                        valid_next = 1'b1;
                        skid_drain = 1'b1;
                        pc_advance = 1'b1;
                    end else if (imem_req && imem_ready) begin
                        if (!PCcont) begin
                            instr_next   = imem_rdata;
                            pcplus4_next = pc_plus4;
                            valid_next   = 1'b1;
                            pc_advance   = 1'b1;
                        end else begin
                            skid_load = 1'b1;
                        end
                    end
                end
                DISCARD: begin
                    imem_req  = 1'b1;
                    imem_addr = req_addr_reg;
                    if (flush) begin
                        instr_next = NOP;
                        valid_next = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_addr_reg <= RESET_PC;
            instr_reg    <= NOP;
            pcplus4_reg  <= RESET_PC + 32'd4;
            valid_reg    <= 1'b0;
        end else begin
            if (state_reg == FETCH && imem_req) req_addr_reg <= pc;
            instr_reg   <= instr_next;
            pcplus4_reg <= pcplus4_next;
            valid_reg   <= valid_next;
        end
    end

    assign IF_ID_Instruction = instr_reg;
    assign IF_ID_PCplus4     = pcplus4_reg;
    assign IF_ID_valid       = valid_reg;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: stream, wait states, stall skid, flush/discard, reset, wrap.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        PCcont, flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] IF_ID_Instruction, IF_ID_PCplus4;
    logic        IF_ID_valid, pc_advance;

    int tests_run = 0;
    int tests_failed = 0;

    if_fetch_stage dut (
        .clk               (clk),
        .reset             (reset),
        .pc                (pc),
        .PCcont            (PCcont),
        .flush             (flush),
        .imem_req          (imem_req),
        .imem_addr         (imem_addr),
        .imem_ready        (imem_ready),
        .imem_rdata        (imem_rdata),
        .IF_ID_Instruction (IF_ID_Instruction),
        .IF_ID_PCplus4     (IF_ID_PCplus4),
        .IF_ID_valid       (IF_ID_valid),
        .pc_advance        (pc_advance)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] p, input logic rdy, input logic [31:0] d,
                         input logic st, input logic fl);
        pc = p; imem_ready = rdy; imem_rdata = d; PCcont = st; flush = fl;
    endtask

    task automatic to_neg();
        @(negedge clk);
    endtask

    task automatic to_pos();
        @(posedge clk); #1;
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] ins, input logic [31:0] p4,
                            input logic v);
        chk({tag, ".instr"}, IF_ID_Instruction, ins);
        chk({tag, ".pc4"}, IF_ID_PCplus4, p4);
        chk({tag, ".valid"}, {31'd0, IF_ID_valid}, {31'd0, v});
        $display("[TB] %s instr=%h pc4=%h valid=%0b", tag, IF_ID_Instruction, IF_ID_PCplus4, IF_ID_valid);
    endtask

    initial begin
        logic [31:0] p, w;
        reset = 1'b0;
        drive(32'h0040_0000, 1'b0, 32'h0, 1'b0, 1'b0);

        // reset state
        to_neg();
        chk("rst.req", {31'd0, imem_req}, 32'd0);
        chk("rst.adv", {31'd0, pc_advance}, 32'd0);
        chk_ifid("rst", 32'h0, 32'h0040_0004, 1'b0);
        to_pos();
        reset = 1'b1;

        // zero-wait stream
        for (int k = 0; k < 4; k++) begin
            p = 32'h0040_0000 + 32'(4 * k);
            w = 32'h1111_0000 + 32'(k);
            drive(p, 1'b1, w, 1'b0, 1'b0);
            to_neg();
            chk("zw.req", {31'd0, imem_req}, 32'd1);
            chk("zw.addr", imem_addr, p);
            chk("zw.adv", {31'd0, pc_advance}, 32'd1);
            to_pos();
            chk_ifid("zw", w, p + 32'd4, 1'b1);
        end

        // two wait states
        for (int c = 0; c < 3; c++) begin
            drive(32'h0040_0010, c == 2, (c == 2) ? 32'h2222_0000 : 32'hBAD0_BAD0, 1'b0, 1'b0);
            to_neg();
            chk("ws.addr", imem_addr, 32'h0040_0010);
            chk("ws.adv", {31'd0, pc_advance}, (c == 2) ? 32'd1 : 32'd0);
            to_pos();
            if (c < 2) chk_ifid("ws.hold", 32'h1111_0003, 32'h0040_0010, 1'b1);
        end
        chk_ifid("ws.done", 32'h2222_0000, 32'h0040_0014, 1'b1);

        // stall when the response lands -> skid
        drive(32'h0040_0014, 1'b1, 32'h8C01_0004, 1'b1, 1'b0);
        to_neg();
        chk("stall.adv", {31'd0, pc_advance}, 32'd0);
        to_pos();
        chk_ifid("stall.hold", 32'h2222_0000, 32'h0040_0014, 1'b1);
        drive(32'h0040_0014, 1'b0, 32'h0, 1'b1, 1'b0);
        to_neg();
        chk("stall.req", {31'd0, imem_req}, 32'd0);
        chk("stall.adv2", {31'd0, pc_advance}, 32'd0);
        to_pos();
        chk_ifid("stall.hold2", 32'h2222_0000, 32'h0040_0014, 1'b1);
        drive(32'h0040_0014, 1'b0, 32'h0, 1'b0, 1'b0);
        to_neg();
        chk("drain.req", {31'd0, imem_req}, 32'd0);
        chk("drain.adv", {31'd0, pc_advance}, 32'd1);
        to_pos();
        chk_ifid("drain", 32'h8C01_0004, 32'h0040_0018, 1'b1);

        // flush one cycle into a 3-wait fetch
        drive(32'h0040_0008, 1'b0, 32'h0, 1'b0, 1'b0);
        to_neg();
        chk("fl.addr0", imem_addr, 32'h0040_0008);
        to_pos();
        drive(32'h0040_0008, 1'b0, 32'h0, 1'b0, 1'b1);
        to_neg();
        chk("fl.adv", {31'd0, pc_advance}, 32'd0);
        to_pos();
        chk_ifid("fl.squash", 32'h0, 32'h0040_0018, 1'b0);
        drive(32'h0040_0040, 1'b0, 32'h0, 1'b0, 1'b0);
        to_neg();
        chk("disc.req", {31'd0, imem_req}, 32'd1);
        chk("disc.addr", imem_addr, 32'h0040_0008);
        to_pos();
        drive(32'h0040_0040, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
        to_neg();
        chk("disc.adv", {31'd0, pc_advance}, 32'd0);
        to_pos();
        chk_ifid("disc.drop", 32'h0, 32'h0040_0018, 1'b0);
        drive(32'h0040_0040, 1'b1, 32'h3333_0040, 1'b0, 1'b0);
        to_neg();
        chk("refetch.addr", imem_addr, 32'h0040_0040);
        chk("refetch.adv", {31'd0, pc_advance}, 32'd1);
        to_pos();
        chk_ifid("refetch", 32'h3333_0040, 32'h0040_0044, 1'b1);

        // flush + stall with the skid full
        drive(32'h0040_0044, 1'b1, 32'h4444_0000, 1'b1, 1'b0);
        to_pos();
        drive(32'h0040_0044, 1'b0, 32'h0, 1'b1, 1'b1);
        to_neg();
        chk("fs.req", {31'd0, imem_req}, 32'd0);
        chk("fs.adv", {31'd0, pc_advance}, 32'd0);
        to_pos();
        chk_ifid("fs", 32'h0, 32'h0040_0044, 1'b0);
        drive(32'h0040_0044, 1'b0, 32'h0, 1'b0, 1'b0);
        to_neg();
        chk("fs.req_after", {31'd0, imem_req}, 32'd1);
        chk("fs.adv_after", {31'd0, pc_advance}, 32'd0);
        to_pos();
        chk("fs.valid_after", {31'd0, IF_ID_valid}, 32'd0);

        // flush together with ready: no discard state
        drive(32'h0040_0050, 1'b1, 32'hAAAA_0000, 1'b0, 1'b1);
        to_neg();
        chk("flr.adv", {31'd0, pc_advance}, 32'd0);
        to_pos();
        chk("flr.valid", {31'd0, IF_ID_valid}, 32'd0);
        drive(32'h0040_0060, 1'b0, 32'h0, 1'b0, 1'b0);
        to_neg();
        chk("flr.addr", imem_addr, 32'h0040_0060);
        to_pos();

        // pc+4 wraps
        drive(32'hFFFF_FFFC, 1'b1, 32'h7777_0000, 1'b0, 1'b0);
        to_pos();
        chk_ifid("wrap", 32'h7777_0000, 32'h0000_0000, 1'b1);

        // reset mid-wait
        drive(32'h0040_0064, 1'b0, 32'h0, 1'b0, 1'b0);
        #2 reset = 1'b0;
        #1;
        chk("mrst.req", {31'd0, imem_req}, 32'd0);
        chk("mrst.adv", {31'd0, pc_advance}, 32'd0);
        chk_ifid("mrst", 32'h0, 32'h0040_0004, 1'b0);
        to_pos();
        reset = 1'b1;
        drive(32'h0040_0100, 1'b1, 32'h5555_0000, 1'b0, 1'b0);
        to_neg();
        chk("post.addr", imem_addr, 32'h0040_0100);
        chk("post.adv", {31'd0, pc_advance}, 32'd1);
        to_pos();
        chk_ifid("post", 32'h5555_0000, 32'h0040_0104, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
